// File: rtl/fir_interp_dac_if.sv
// Sample-stream bundle for fir_interp_dac: low-rate input handshake,
// interpolated DAC output strobe and the sticky saturation flag with its clear.
interface fir_interp_dac_if #(
  parameter int WIDTH = 14
);
  logic signed [WIDTH-1:0] din;
  logic                    din_valid;
  logic                    din_ready;
  logic signed [WIDTH-1:0] dout;
  logic                    dout_valid;
  logic                    sat_flag;
  logic                    sat_clr;

  modport master (
    output din, din_valid, sat_clr,
    input  din_ready, dout, dout_valid, sat_flag
  );

  modport slave (
    input  din, din_valid, sat_clr,
    output din_ready, dout, dout_valid, sat_flag
  );
endinterface

// File: rtl/fir_interp_dac.sv
// 1:4 polyphase FIR interpolator feeding a DAC; one shared MAC walks 4 taps per phase.
// Define FIR_INTERP_SAT_EN to clamp the output and drive sat_flag; otherwise the output wraps.
module fir_interp_dac #(
  parameter int WIDTH = 14,
  parameter int N     = 16,
  parameter int L     = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  fir_interp_dac_if.slave  bus
);

  localparam int TPP   = N / L;
  localparam int ACC_W = WIDTH + 18;
  localparam int PROD_W = WIDTH + 16;

  localparam logic [1:0] PH_LAST  = 2'(L - 1);
  localparam logic [1:0] TAP_LAST = 2'(TPP - 1);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic                    ready;
  logic                    accept;
  logic [1:0]              phase;
  logic [1:0]              tap;
  logic signed [WIDTH-1:0] hist [TPP];
  logic signed [ACC_W-1:0] acc;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [WIDTH-1:0] result_p1;
  logic signed [WIDTH-1:0] dout_q;
  logic                    dout_valid_q;

  // Prototype taps are symmetric, so each case arm covers a mirrored pair.
  function automatic logic signed [15:0] coef(input logic [3:0] idx);
    case (idx)
      4'd0,  4'd15: coef = 16'sd112;
      4'd1,  4'd14: coef = 16'sd243;
      4'd2,  4'd13: coef = 16'sd618;
      4'd3,  4'd12: coef = 16'sd1293;
      4'd4,  4'd11: coef = 16'sd2217;
      4'd5,  4'd10: coef = 16'sd3225;
      4'd6,  4'd9:  coef = 16'sd4089;
      4'd7,  4'd8:  coef = 16'sd4587;
      default:      coef = 16'sd0;
    endcase
  endfunction

  // Q15 coefficients times interpolation gain 4 leaves a net shift of 13.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] bias;
    bias = ACC_W'(4096);
    return (a + bias) >>> 13;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] s);
    return (s > MAX_V) || (s < MIN_V);
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] s);
    if (s > MAX_V)      return MAX_V[WIDTH-1:0];
    else if (s < MIN_V) return MIN_V[WIDTH-1:0];
    else                return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] wrap(input logic signed [ACC_W-1:0] s);
    return s[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.din_valid) state_nx = MAC;
      end
      MAC:     if (tap == TAP_LAST) state_nx = OUT;
      OUT:     state_nx = (phase == PH_LAST) ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  assign accept        = ready && bus.din_valid;
  assign bus.din_ready = ready;

  // Stage p0: one tap product per MAC cycle; coefficient index is phase + 4*tap.
  assign prod_p0 = PROD_W'(hist[tap]) * PROD_W'(coef({tap, phase}));

  // Stage p1: scale the finished phase sum down to DAC width.
`ifdef FIR_INTERP_SAT_EN
  assign result_p1 = clamp(round_shift(acc));
`else
  assign result_p1 = wrap(round_shift(acc));
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < TPP; k++) hist[k] <= '0;
      acc          <= '0;
      phase        <= '0;
      tap          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (accept) begin
        hist[0] <= bus.din;
        for (int k = 1; k < TPP; k++) hist[k] <= hist[k-1];
        acc   <= '0;
        phase <= '0;
        tap   <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod_p0);
        tap <= tap + 2'd1;
      end
      if (state == OUT) begin
        dout_q       <= result_p1;
        dout_valid_q <= 1'b1;
        if (phase != PH_LAST) begin
          phase <= phase + 2'd1;
          acc   <= '0;
          tap   <= '0;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

`ifdef FIR_INTERP_SAT_EN
  logic sat_q;

  // A clamp in the same cycle as a clear wins, so no saturation event is lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sat_q <= 1'b0;
    end else if (state == OUT && sat_hit(round_shift(acc))) begin
      sat_q <= 1'b1;
    end else if (bus.sat_clr) begin
      sat_q <= 1'b0;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = bus.sat_clr;
  assign bus.sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_interp_dac.sv
// Scoreboard bench for fir_interp_dac: a driver pushes expected outputs from an
// arithmetic reference model, a negedge monitor pops and compares each strobe.
`timescale 1ns/1ps
module tb_fir_interp_dac;

  localparam int W    = 14;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));
`ifdef FIR_INTERP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;

  fir_interp_dac_if #(.WIDTH(W)) bus ();

  fir_interp_dac #(.WIDTH(W), .N(16), .L(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
    bit clamp;
    int ph;
  } exp_t;

  exp_t q[$];
  int   got[$];
  int   acc_cyc[$];
  exp_t e;

  int C[16] = '{112, 243, 618, 1293, 2217, 3225, 4089, 4587,
                4587, 4089, 3225, 2217, 1293, 618, 243, 112};
  int hist[4];

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int strobes = 0;
  int last_ph = -1;
  int last_dout = 0;
  bit mflag = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: full-rate upsampled convolution output for phase p equals
  // sum over the 4 newest samples of x[t]*h[p+4t], then gain 4 / Q15 scaling.
  function automatic int model_out(input int p, output bit clamped);
    longint acc_m = 0;
    longint s;
    for (int t = 0; t < 4; t++) acc_m += longint'(hist[t]) * longint'(C[p + 4 * t]);
    s = (acc_m + 64'sd4096) >>> 13;
    clamped = 1'b0;
    if (SAT) begin
      if (s > MAXV) begin clamped = 1'b1; s = MAXV; end
      else if (s < MINV) begin clamped = 1'b1; s = MINV; end
    end else begin
      s = s & ((64'sd1 << W) - 1);
      if (s > MAXV) s = s - (64'sd1 << W);
    end
    return int'(s);
  endfunction

  task automatic accept_model(input int v);
    exp_t x;
    bit   c;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    for (int p = 0; p < 4; p++) begin
      x.val   = model_out(p, c);
      x.clamp = c;
      x.ph    = p;
      x.due   = cyc + 1 + 5 * (p + 1);
      q.push_back(x);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offers v until accepted; the accepting edge is the next rising edge.
  task automatic send(input int v, input bit hold);
    int waited = 0;
    bus.din       = W'(v);
    bus.din_valid = 1'b1;
    while (!bus.din_ready && waited < 60) begin
      tick();
      waited++;
    end
    if (!bus.din_ready) begin
      check("accept_timeout", 0, 1);
      bus.din_valid = 1'b0;
      return;
    end
    accept_model(v);
    acc_cyc.push_back(cyc + 1);
    @(posedge clk);
    #1;
    if (!hold) bus.din_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() > 0 && b < 200) begin
      tick();
      b++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic wait_strobes(input int n);
    int b = 0;
    while (strobes < n && b < 200) begin
      tick();
      b++;
    end
    check("strobe_wait", int'(strobes >= n), 1);
  endtask

  task automatic check_last4(input string name, input int v0, input int v1, input int v2, input int v3);
    int n;
    n = got.size();
    if (n < 4) begin
      check({name, "_count"}, n, 4);
      return;
    end
    check({name, "_p0"}, got[n-4], v0);
    check({name, "_p1"}, got[n-3], v1);
    check({name, "_p2"}, got[n-2], v2);
    check({name, "_p3"}, got[n-1], v3);
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      last_dout = 0;
    end else if (bus.dout_valid) begin
      if (q.size() == 0) begin
        check("spurious_strobe", 0, 1);
      end else begin
        e = q.pop_front();
        check("dout_time", cyc, e.due);
        check("dout_val", int'(bus.dout), e.val);
        if (e.clamp) mflag = 1'b1;
        check("sat_flag", int'(bus.sat_flag), int'(mflag));
        got.push_back(int'(bus.dout));
        last_ph = e.ph;
      end
      strobes++;
      last_dout = int'(bus.dout);
    end else begin
      check("dout_hold", int'(bus.dout), last_dout);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, n, v, expv;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.sat_clr = 1'b0;
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    #1;
    check("rst_ready", int'(bus.din_ready), 1);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_valid", int'(bus.dout_valid), 0);
    check("rst_sat", int'(bus.sat_flag), 0);
    repeat (3) @(negedge clk);
    #1 n_rst = 1'b1;
    tick();
    check("ready_after_rst", int'(bus.din_ready), 1);

    // Impulse response
    send(1000, 1'b0);
    drain();
    check_last4("impulse", 14, 30, 75, 158);

    // Valid held high: steady 2000 and back-to-back acceptance spacing
    tick();
    base = strobes;
    acc_cyc.delete();
    for (int i = 0; i < 5; i++) send(2000, 1'b1);
    bus.din_valid = 1'b0;
    drain();
    for (int i = 1; i < acc_cyc.size(); i++)
      check("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 21);
    check("strobes_per_accept", strobes - base, 4 * 5);
    check_last4("steady2000", 2004, 1996, 1996, 2004);

    // Positive full scale held
    tick();
    for (int i = 0; i < 5; i++) send(8191, 1'b0);
    drain();
    expv = SAT ? 8191 : -8176;
    n = got.size();
    check("pos_fs_p0", got[n-4], expv);
    check("pos_fs_p3", got[n-1], expv);
    check("pos_fs_flag", int'(bus.sat_flag), int'(SAT));

    // Clear between saturations, then clear colliding with a saturating phase
    tick();
    base = strobes;
    send(8191, 1'b0);
    wait_strobes(base + 1);
    check("clr_burst_phase", last_ph, 0);
    k = cyc;
    bus.sat_clr = 1'b1;
    mflag = 1'b0;
    tick();
    bus.sat_clr = 1'b0;
    check("sat_clr", int'(bus.sat_flag), 0);
    while (cyc < k + 14) tick();
    bus.sat_clr = 1'b1;
    mflag = 1'b0;
    tick();
    bus.sat_clr = 1'b0;
    check("clr_vs_set", int'(bus.sat_flag), int'(SAT));
    drain();

    tick();
    bus.sat_clr = 1'b1;
    mflag = 1'b0;
    tick();
    bus.sat_clr = 1'b0;
    check("sat_clr_idle", int'(bus.sat_flag), 0);

    // Negative full scale held
    for (int i = 0; i < 5; i++) send(-8192, 1'b0);
    drain();
    expv = SAT ? -8192 : 8175;
    n = got.size();
    check("neg_fs_p0", got[n-4], expv);
    check("neg_fs_p3", got[n-1], expv);
    check("neg_fs_flag", int'(bus.sat_flag), int'(SAT));

    // Randomized samples with random idle gaps
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 16383)) - 8192;
      repeat ($urandom_range(0, 30)) tick();
      send(v, 1'b0);
    end
    drain();

    // Reset in the middle of phase 2
    tick();
    base = strobes;
    send(1000, 1'b0);
    wait_strobes(base + 2);
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    check("midrst_dout", int'(bus.dout), 0);
    check("midrst_valid", int'(bus.dout_valid), 0);
    check("midrst_ready", int'(bus.din_ready), 1);
    check("midrst_sat", int'(bus.sat_flag), 0);
    q.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    mflag = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("ready_after_midrst", int'(bus.din_ready), 1);
    base = strobes;
    repeat (20) tick();
    check("no_stale_phases", strobes, base);
    send(1000, 1'b0);
    drain();
    check_last4("impulse_after_rst", 14, 30, 75, 158);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fir_interp_dac.md
FIR_INTERP_DAC -- requirements
Module: fir_interp_dac

Interface
REQ-001 Parameter WIDTH, default 14, sets signed sample width of din and dout (DAC width).
REQ-002 Parameter N, default 16, sets prototype tap count; N SHALL be 16.
REQ-003 Parameter L, default 4, sets interpolation factor; L SHALL be 4 (4 phases x 4 taps).
REQ-004 clk  input  1  single clock; all logic SHALL run on its rising edge.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 din  input  WIDTH  signed low-rate input sample.
REQ-007 din_valid  input  1  din holds a sample.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 dout  output  WIDTH  signed interpolated sample for the DAC.
REQ-010 dout_valid  output  1  one-cycle strobe marking a new dout.
REQ-011 sat_flag  output  1  sticky saturation indicator.
REQ-012 sat_clr  input  1  synchronous clear of sat_flag.

Function
REQ-013 Coefficients SHALL be fixed signed 16-bit Q15: 112,243,618,1293,2217,3225,4089,4587,4587,4089,3225,2217,1293,618,243,112 (c0..c15).
REQ-014 History SHALL be 4 registered samples x0 (newest)..x3; acceptance SHALL shift x0<=din, xk<=x(k-1).
REQ-015 Acceptance SHALL occur on an edge where din_valid and din_ready are both 1.
REQ-016 FSM states SHALL be IDLE, MAC, OUT; din_ready SHALL be 1 only in IDLE.
REQ-017 IDLE->MAC on acceptance, phase<=0, tap<=0, accumulator<=0.
REQ-018 MAC SHALL last exactly 4 cycles, accumulating x_tap*c(phase+4*tap) for tap 0..3, then go to OUT.
REQ-019 OUT SHALL last 1 cycle, register dout, pulse dout_valid; if phase<3 then phase+1, clear accumulator, go to MAC; else go to IDLE.
REQ-020 Output for phase p SHALL be valid 5*(p+1) cycles after the acceptance edge; 4 outputs per input; next acceptance no earlier than 21 cycles after the previous one.
REQ-021 Accumulator SHALL be signed WIDTH+18 bits with no overflow possible.
REQ-022 Scaling SHALL be (acc + 4096) arithmetic-shifted right by 13 (gain L, round half up).
REQ-023 din_valid while din_ready=0 SHALL be ignored; source holds the sample.
REQ-024 dout SHALL hold its value between strobes.
REQ-025 sat_clr and a new saturation in the same cycle: sat_flag SHALL end at 1.

Reset
REQ-026 n_rst low SHALL immediately force state IDLE, history/accumulator/phase/tap 0, dout 0, dout_valid 0, sat_flag 0.
REQ-027 din_ready SHALL be 1 in reset and in the first cycle after release; reset mid-burst SHALL discard remaining phases.

Configuration
REQ-028 Macro FIR_INTERP_SAT_EN defined: scaled result SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat_flag on clamping.
REQ-029 FIR_INTERP_SAT_EN undefined: scaled result SHALL be truncated to WIDTH bits (two's-complement wrap); sat_flag SHALL be constant 0 and sat_clr ignored.

Verification
REQ-030 Reset, accept din=1000 once, then zeros -> first four dout = 14, 30, 75, 158 at +5, +10, +15, +20 cycles.
REQ-031 din=2000 held over >=5 acceptances -> steady dout repeating 2004, 1996, 1996, 2004.
REQ-032 din=8191 held, SAT_EN defined -> phases 0 and 3 give 8191, sat_flag=1; sat_clr pulse -> 0, re-set next saturation; SAT_EN undefined -> phase 0 gives -8176, sat_flag=0.
REQ-033 din=-8192 held, SAT_EN defined -> phases 0 and 3 give -8192, sat_flag=1.
REQ-034 din_valid held 1 for 100 cycles -> acceptances exactly 21 cycles apart, exactly 4 dout_valid strobes per acceptance, din_ready=0 during bursts.
REQ-035 n_rst asserted during phase 2 -> dout=0, dout_valid=0 immediately; after release din_ready=1 and din=1000 impulse reproduces REQ-030 values.
